regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (reg_write/RW/Bus_W) between two writeback requesters:
//  A = ALU writeback, B = load writeback. Round-robin arbitration, valid/ready handshake and a registered
//  write stage. Sits between the execute/memory stages and RegFile; optional read-port forwarding.
// PARAMETERS
//  ADDR_W   5    register index width (32 registers)
//  DATA_W   32   register data width
//  CNT_W    16   width of saturating conflict counter
// PORTS
//  clk           in   1       system clock, all state updates on posedge
//  rst_n         in   1       asynchronous reset, active-low
//  wb_stall      in   1       1 = accept nothing this cycle (both ready low)
//  a_valid       in   1       requester A has a write
//  a_rw          in   ADDR_W  requester A destination register
//  a_data        in   DATA_W  requester A write data
//  a_ready       out  1       A's request accepted this cycle
//  b_valid       in   1       requester B has a write
//  b_rw          in   ADDR_W  requester B destination register
//  b_data        in   DATA_W  requester B write data
//  b_ready       out  1       B's request accepted this cycle
//  reg_write     out  1       RegFile write enable (registered)
//  RW            out  ADDR_W  RegFile write index (registered)
//  Bus_W         out  DATA_W  RegFile write data (registered)
//  conflict_cnt  out  CNT_W   cycles where both requesters were valid and not stalled, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): reg_write=0, RW=0, Bus_W=0, conflict_cnt=0, priority state=PRI_A; readies 0.
//  - Priority FSM, 2 states: PRI_A (A wins ties), PRI_B (B wins ties). On a conflict grant, state moves to
//    favour the loser; a sole-requester grant sets state to favour the other side. No grant -> hold.
//  - Grant is combinational: x_ready = x_valid & ~wb_stall & (x is sole requester or has priority).
//    At most one ready high per cycle. Handshake completes when valid & ready; requester must hold
//    valid/rw/data stable until ready. No request is ever dropped.
//  - Latency 1: accepted request appears on RW/Bus_W with reg_write=1 on the next cycle for exactly one
//    cycle; back-to-back accepts give reg_write high every cycle.
//  - Destination 0: request is accepted (ready=1) but reg_write stays 0 next cycle; R0 never written.
//  - No accept in a cycle: reg_write=0 next cycle; RW/Bus_W hold last value.
//  - Same destination from A and B in one cycle: both written sequentially in grant order; later write wins.
//  - conflict_cnt increments by 1 per conflict cycle, stops at 2^CNT_W-1 (no wrap).
//  - Reset mid-operation: in-flight registered write is discarded (reg_write forced 0 immediately).
// CONFIGURATION
//  Macro REGFILE_WB_FWD_EN:
//  - defined: adds ports RA, RB (in, ADDR_W), rf_bus_a, rf_bus_b (in, DATA_W, raw RegFile reads),
//    Bus_A, Bus_B (out, DATA_W). Bus_A = Bus_W when reg_write & RW==RA & RA!=0, else rf_bus_a; same for B.
//    Purely combinational bypass of the pending write.
//  - undefined: ports absent; no forwarding logic; readers see RegFile directly.
// STRUCTURE
//  - Package regfile_pkg: ADDR_W/DATA_W constants, typedef wb_req_t {rw, data}, enum prio_e {PRI_A, PRI_B}.
//  - Sub-module rr_arbiter2: 2-way round-robin grant + priority FSM (inputs req[1:0], en; outputs gnt[1:0]).
//  - Top: output register stage, R0 suppression, conflict counter, optional forwarding mux.
// TESTING
//  1. Reset: rst_n=0 with a_valid=1 -> reg_write=0, conflict_cnt=0, a_ready=0; release -> a_ready=1.
//  2. A only: a_rw=3,a_data=0xAA -> a_ready=1 same cycle; next cycle reg_write=1,RW=3,Bus_W=0xAA, then 0.
//  3. Both valid 4 cycles (a_rw=1, b_rw=2) -> grants A,B,A,B; conflict_cnt=4 (each requester re-asserts).
//  4. a_rw=0,a_data=0x55 -> a_ready=1, reg_write stays 0 next cycle.
//  5. wb_stall=1 with both valid -> both ready 0, reg_write 0 next cycle, conflict_cnt unchanged.
//  6. FWD_EN: write RW=7,Bus_W=0x1234 pending, RA=7, rf_bus_a=0 -> Bus_A=0x1234; RA=0 -> Bus_A=rf_bus_a.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Holds the default register-file geometry, the writeback request record and the priority state encoding.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } prio_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority state.
// req[0]/gnt[0] belong to requester A, req[1]/gnt[1] to requester B.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    prio_e prio;

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = en & req[0] & (~req[1] | (prio == PRI_A));
        gnt[1] = en & req[1] & (~req[0] | (prio == PRI_B));
    end

    // Whoever was just served, the other side is favoured next; no grant holds state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio <= PRI_A;
        else if (gnt[0])
            prio <= PRI_B;
        else if (gnt[1])
            prio <= PRI_A;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegFile write port between ALU (A) and load (B) writebacks with a registered write stage.
// Define REGFILE_WB_FWD_EN to add the combinational read-port bypass of the pending write.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rw,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rw,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] Bus_W,
`ifdef REGFILE_WB_FWD_EN
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [DATA_W-1:0] rf_bus_a,
    input  logic [DATA_W-1:0] rf_bus_b,
    output logic [DATA_W-1:0] Bus_A,
    output logic [DATA_W-1:0] Bus_B,
`endif
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0]        gnt;
    logic              accept;
    logic              conflict;
    logic [ADDR_W-1:0] sel_rw;
    logic [DATA_W-1:0] sel_data;

    // Readies are held low during reset so nothing is handshaken while the stage is cleared.
    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~wb_stall & rst_n),
        .req   ({b_valid, a_valid}),
        .gnt   (gnt)
    );

    assign a_ready  = gnt[0];
    assign b_ready  = gnt[1];
    assign accept   = |gnt;
    assign conflict = a_valid & b_valid & ~wb_stall;

    always_comb begin
        sel_rw   = a_rw;
        sel_data = a_data;
        if (gnt[1]) begin
            sel_rw   = b_rw;
            sel_data = b_data;
        end
    end

    // R0 requests are consumed but never reach the RegFile; index/data hold their last real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write <= 1'b0;
            RW        <= '0;
            Bus_W     <= '0;
        end else begin
            reg_write <= accept & (sel_rw != '0);
            if (accept && sel_rw != '0) begin
                RW    <= sel_rw;
                Bus_W <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (conflict && conflict_cnt != {CNT_W{1'b1}})
            conflict_cnt <= conflict_cnt + 1'b1;
    end

`ifdef REGFILE_WB_FWD_EN
    assign Bus_A = (reg_write && RW == RA && RA != '0) ? Bus_W : rf_bus_a;
    assign Bus_B = (reg_write && RW == RB && RB != '0) ? Bus_W : rf_bus_b;
`endif

endmodule
